priority_decoder_24: RTL and testbench
======================================

Name: priority_decoder_24

Overview:
Reverse end of the 4-to-2 priority encoder interface. Consumes 3-bit priority codes (0 = no request, 1..4 = request line 0..3) over a valid/ready handshake and buffers them in a small FIFO. Replays each code as a one-hot grant on o_grant[3:0], held for a fixed number of cycles and followed by a programmable idle gap. Sits between the encoder's output and the shared resource it arbitrates.

Parameters:
DEPTH, 4, FIFO depth in entries; power of 2, >= 2
HOLD, 3, cycles each grant is held high; >= 1
GAP, 1, idle cycles forced after each grant; >= 0

Ports:
i_clk  in  1  clock; all logic on the rising edge
i_rst  in  1  reset; synchronous, active-high
i_pcode  in  3  priority code: 000 none, 001..100 line 0..3, 101..111 illegal
i_valid  in  1  i_pcode is valid this cycle
o_ready  out  1  block accepts a code this cycle
o_grant  out  4  one-hot grant, registered
o_busy  out  1  high whenever the FSM is not in IDLE
o_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_err  out  1  sticky flag, set by an illegal code
i_err_clr  in  1  clears o_err

Behaviour:
- Reset: FSM goes to IDLE, FIFO empties, o_grant=0, o_busy=0, o_count=0, o_err=0.
- o_ready=0 while i_rst=1. Otherwise o_ready = (o_count != DEPTH).
- Reset asserted mid-grant: o_grant drops to 0 at that edge. Queued entries are discarded and never granted.
- Accept: a code is accepted when i_valid && o_ready at a rising edge.
  - Codes 1..4 are pushed as a 2-bit index (code-1).
  - Code 0 is accepted and dropped.
  - Codes 5..7 are accepted and dropped, and o_err=1 from the next cycle.
- o_err stays set until i_err_clr. If an illegal accept and i_err_clr occur in the same cycle, set wins.
- Full FIFO: no push, even if a pop occurs in the same cycle. o_ready is low, so the sender holds its code.
- Empty FIFO: a push and a pop cannot coincide. The FSM only pops an entry that is already stored.
- FSM has three states: IDLE, GRANT, GAP. A down-counter of width clog2(max(HOLD,GAP,1))+1 is shared by GRANT and GAP.
  - IDLE: if FIFO is non-empty, pop the head, register o_grant = 1<<index, load counter = HOLD-1, go to GRANT.
  - GRANT: o_grant held. If counter != 0, decrement. If counter == 0:
    - GAP > 0: clear o_grant, load counter = GAP-1, go to GAP.
    - GAP == 0 and FIFO non-empty: pop and load the next grant at the same edge (back-to-back), counter = HOLD-1, stay in GRANT.
    - Otherwise: clear o_grant, go to IDLE.
  - GAP: o_grant=0. If counter != 0, decrement. If counter == 0 and FIFO non-empty, pop and go to GRANT. Otherwise go to IDLE.
- Latency: a code accepted at the end of cycle c into an empty FIFO, with the FSM in IDLE, gives o_grant high in cycles c+2 .. c+1+HOLD.
- o_grant is always zero or one-hot. It is never X after reset.
- o_count updates at the edge of push and/or pop. A simultaneous push and pop leaves it unchanged.

Decomposition:
- Shared package holds:
  - code constants PCODE_NONE=3'b000, PCODE_R0..PCODE_R3 = 3'b001..3'b100
  - FSM state encoding (IDLE, GRANT, GAP)
  - a function mapping a 2-bit index to a 4-bit one-hot value
- The encoder side uses the same constants.
- One sub-module, sync_fifo (parameters DEPTH, WIDTH=2): synchronous-reset FIFO with push, pop, dout, count, full, empty. The top level holds the FSM, counter, decode and error logic.

Test Plan:
- Reset, then push 3'b100 in cycle 10 (HOLD=3, GAP=1): o_grant=4'b1000 in cycles 12-14, 0 in cycle 15, o_busy falls in cycle 16, o_count returns to 0.
- Push codes 1,2,3,4 back-to-back: grants 0001, 0010, 0100, 1000, each 3 cycles, separated by exactly 1 zero cycle, no code lost.
- Hold i_valid for 8 consecutive codes: o_count reaches 4 and o_ready=0. The held code is accepted only after a pop frees an entry. Grant order matches push order.
- Push 3'b000, then 3'b110: no grant, o_count stays 0, o_err=1 from the next cycle. Then i_err_clr together with another 3'b111: o_err stays 1. A lone i_err_clr gives o_err=0.
- Queue 3 codes, then assert i_rst for 1 cycle during the first grant: o_grant=0 and o_count=0 the next cycle, no further grants appear.
- GAP=0 build, push codes 2 and 3: o_grant 0010 for 3 cycles immediately followed by 0100 for 3 cycles, with no zero cycle between them.

Source files
------------

// File: rtl/priority_decoder_24_pkg.sv
// Shared code points, FSM encoding and index decode for the priority encoder/decoder pair.
// Used by both ends so the 3-bit wire format stays consistent.
package priority_decoder_24_pkg;

    localparam logic [2:0] PCODE_NONE = 3'b000;
    localparam logic [2:0] PCODE_R0   = 3'b001;
    localparam logic [2:0] PCODE_R1   = 3'b010;
    localparam logic [2:0] PCODE_R2   = 3'b011;
    localparam logic [2:0] PCODE_R3   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/priority_decoder_24_sync_fifo.sv
// Synchronous-reset FIFO holding decoded grant indices.
// Push/pop take effect at the clock edge; pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rptr];
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/priority_decoder_24.sv
// Replays queued 3-bit priority codes as one-hot grants held HOLD cycles, then GAP idle cycles.
// Latency: accept at cycle c into an idle, empty block gives a grant in c+2; o_ready drops while the FIFO is full.
module priority_decoder_24 #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2:0]             i_pcode,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [3:0]             o_grant,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_err,
    input  logic                   i_err_clr
);
    import priority_decoder_24_pkg::*;

    localparam int MAXV = (HOLD > GAP) ? ((HOLD > 1) ? HOLD : 1) : ((GAP > 1) ? GAP : 1);
    localparam int TW   = $clog2(MAXV) + 1;
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
    localparam logic [TW-1:0] GAP_LD  = (GAP > 0) ? TW'(GAP - 1) : '0;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic [3:0]    r_grant;
    logic [3:0]    w_grant_nxt;
    logic          r_err;
    logic          w_err_nxt;

    logic          w_accept;
    logic          w_legal;
    logic          w_illegal;
    logic          w_push;
    logic          w_pop;
    logic [1:0]    w_din;
    logic [1:0]    w_dout;
    logic          w_full;
    logic          w_empty;

    // Code 0 and illegal codes are consumed but never reach the FIFO.
    assign o_ready   = !i_rst && !w_full;
    assign w_accept  = i_valid && o_ready;
    assign w_legal   = (i_pcode >= PCODE_R0) && (i_pcode <= PCODE_R3);
    assign w_illegal = (i_pcode > PCODE_R3);
    assign w_push    = w_accept && w_legal;
    assign w_din     = 2'(i_pcode - PCODE_R0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
            r_grant <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_grant <= w_grant_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_grant_nxt = r_grant;
        w_pop       = 1'b0;
        w_err_nxt   = r_err;

        if (w_accept && w_illegal) begin
            w_err_nxt = 1'b1;
        end else if (i_err_clr) begin
            w_err_nxt = 1'b0;
        end

        // Pops only look at w_empty, so an entry pushed this cycle is never granted at the same edge.
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_grant_nxt = idx_to_onehot(w_dout);
                    w_tmr_nxt   = HOLD_LD;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end else if (GAP > 0) begin
                    w_grant_nxt = '0;
                    w_tmr_nxt   = GAP_LD;
                    w_state_nxt = ST_GAP;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_grant_nxt = idx_to_onehot(w_dout);
                    w_tmr_nxt   = HOLD_LD;
                end else begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_grant_nxt = idx_to_onehot(w_dout);
                    w_tmr_nxt   = HOLD_LD;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_err   = r_err;

endmodule

// File: tb/tb_priority_decoder_24.sv
// Bench for priority_decoder_24: a GAP=1 and a GAP=0 instance share stimulus and are checked
// against a slot-schedule model plus a directed vector table and hand sequences.
module tb_priority_decoder_24;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int GAP_A = 1;
    localparam int LOGN  = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic       clr;
    logic [2:0] pcode;

    logic       rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;
    logic [3:0] gnt_a, gnt_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    priority_decoder_24 #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_pcode(pcode), .i_valid(valid),
        .o_ready(rdy_a), .o_grant(gnt_a), .o_busy(busy_a), .o_count(cnt_a),
        .o_err(err_a), .i_err_clr(clr)
    );

    priority_decoder_24 #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_pcode(pcode), .i_valid(valid),
        .o_ready(rdy_b), .o_grant(gnt_b), .o_busy(busy_b), .o_count(cnt_b),
        .o_err(err_b), .i_err_clr(clr)
    );

    // Model: every accepted legal code becomes a slot that starts at max(accept+2, end of previous slot)
    // and occupies HOLD grant cycles plus the instance's gap cycles.
    typedef struct {
        int         d;
        int         acc;
        int         st;
        logic [1:0] idx;
    } slot_t;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [2:0] pcode;
        logic       clr;
        logic [3:0] g;
        logic       busy;
        logic [2:0] cnt;
        logic       rdy;
        logic       err;
    } vec_t;

    slot_t      sq[$];
    int         last_end[2];
    logic       err_m[2];
    logic       acc_last[2];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [3:0] log_ga[LOGN];
    logic [3:0] log_gb[LOGN];
    logic [2:0] log_ca[LOGN];
    vec_t       tbl[23];

    function automatic int gapv(input int d);
        return (d == 0) ? GAP_A : 0;
    endfunction

    function automatic int m_occ(input int d, input int t);
        int n = 0;
        foreach (sq[i]) if (sq[i].d == d && sq[i].acc < t && t < sq[i].st) n++;
        return n;
    endfunction

    function automatic logic [3:0] m_grant(input int d, input int t);
        logic [3:0] g = '0;
        foreach (sq[i]) if (sq[i].d == d && sq[i].st <= t && t < sq[i].st + HOLD) g = 4'b0001 << sq[i].idx;
        return g;
    endfunction

    function automatic logic m_busy(input int d, input int t);
        logic b = 1'b0;
        foreach (sq[i]) if (sq[i].d == d && sq[i].st <= t && t < sq[i].st + HOLD + gapv(d)) b = 1'b1;
        return b;
    endfunction

    function automatic logic m_ready(input int d, input int t);
        return !rst && (m_occ(d, t) != DEPTH);
    endfunction

    function automatic vec_t mk(input logic r, input logic v, input logic [2:0] p, input logic c,
                                input logic [3:0] g, input logic b, input logic [2:0] n,
                                input logic rd, input logic e);
        vec_t x;
        x.rst = r; x.valid = v; x.pcode = p; x.clr = c;
        x.g = g; x.busy = b; x.cnt = n; x.rdy = rd; x.err = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (cyc < LOGN) begin
            log_ga[cyc] = gnt_a;
            log_gb[cyc] = gnt_b;
            log_ca[cyc] = cnt_a;
        end
        chk("grant_a", gnt_a, m_grant(0, cyc));
        chk("busy_a",  busy_a, m_busy(0, cyc));
        chk("count_a", cnt_a, m_occ(0, cyc));
        chk("ready_a", rdy_a, m_ready(0, cyc));
        chk("err_a",   err_a, err_m[0]);
        chk("grant_b", gnt_b, m_grant(1, cyc));
        chk("busy_b",  busy_b, m_busy(1, cyc));
        chk("count_b", cnt_b, m_occ(1, cyc));
        chk("ready_b", rdy_b, m_ready(1, cyc));
        chk("err_b",   err_b, err_m[1]);
    endtask

    task automatic model_update();
        slot_t keep[$];
        for (int d = 0; d < 2; d++) begin
            int    st;
            slot_t s;
            acc_last[d] = valid && m_ready(d, cyc);
            if (rst) begin
                keep = {};
                foreach (sq[i]) if (sq[i].d != d) keep.push_back(sq[i]);
                sq = keep;
                last_end[d] = -1000;
                err_m[d] = 1'b0;
            end else begin
                if (acc_last[d] && pcode >= 3'd1 && pcode <= 3'd4) begin
                    st    = (cyc + 2 > last_end[d]) ? cyc + 2 : last_end[d];
                    s.d   = d;
                    s.acc = cyc;
                    s.st  = st;
                    s.idx = 2'(pcode - 3'd1);
                    sq.push_back(s);
                    last_end[d] = st + HOLD + gapv(d);
                end
                if (acc_last[d] && pcode > 3'd4) err_m[d] = 1'b1;
                else if (clr) err_m[d] = 1'b0;
            end
        end
        keep = {};
        foreach (sq[i]) if (sq[i].st + HOLD + 2 >= cyc) keep.push_back(sq[i]);
        sq = keep;
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] p, input logic c);
        rst = r; valid = v; pcode = p; clr = c;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int w;
        int maxc;
        logic [2:0] hold_codes [8];

        last_end[0] = -1000; last_end[1] = -1000;
        err_m[0] = 1'b0;     err_m[1] = 1'b0;
        acc_last[0] = 1'b0;  acc_last[1] = 1'b0;
        hold_codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1};

        // Reset, single code 3'b100 at cycle 10, then code 0 / illegal codes / error clear.
        tbl[0]  = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 4'h0, 0, 0, 0, 0);
        for (int i = 2; i < 10; i++) tbl[i] = mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 4, 0, 4'h0, 0, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 4'h8, 1, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 4'h8, 1, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 4'h8, 1, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[18] = mk(0, 1, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[19] = mk(0, 1, 6, 0, 4'h0, 0, 0, 1, 0);
        tbl[20] = mk(0, 1, 7, 1, 4'h0, 0, 0, 1, 1);
        tbl[21] = mk(0, 0, 0, 1, 4'h0, 0, 0, 1, 1);
        tbl[22] = mk(0, 0, 0, 0, 4'h0, 0, 0, 1, 0);

        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].pcode, tbl[i].clr);
            sample();
            chk("tbl_grant", gnt_a, tbl[i].g);
            chk("tbl_busy",  busy_a, tbl[i].busy);
            chk("tbl_count", cnt_a, tbl[i].cnt);
            chk("tbl_ready", rdy_a, tbl[i].rdy);
            chk("tbl_err",   err_a, tbl[i].err);
            advance();
        end

        // Codes 1..4 back-to-back: four grants of HOLD cycles, one zero cycle between them.
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 3'(k + 1), 0);
            tick();
        end
        drive(0, 0, 0, 0);
        repeat (24) tick();
        for (int k = 0; k < 16; k++)
            chk("seqA_grant", log_ga[c0 + 2 + k], (k % 4 == 3) ? 4'h0 : (4'b0001 << (k / 4)));

        // Eight held codes: the sender waits on backpressure, FIFO must fill to DEPTH.
        c0 = cyc;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, hold_codes[k], 0);
            w = 0;
            do begin
                tick();
                w++;
            end while (!acc_last[0] && w < 40);
            if (!acc_last[0]) begin
                total++;
                bad++;
                $display("FAIL hold_accept k=%0d timed out after %0d cycles", k, w);
            end
        end
        drive(0, 0, 0, 0);
        repeat (40) tick();
        maxc = 0;
        for (int t = c0; t < cyc && t < LOGN; t++) if (int'(log_ca[t]) > maxc) maxc = int'(log_ca[t]);
        chk("seqB_max_count", maxc, DEPTH);

        // Three queued codes, reset during the first grant: everything discarded.
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 3'(k + 1), 0);
            tick();
        end
        drive(1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (15) tick();
        chk("seqC_grant_before_rst", log_ga[c0 + 3], 4'b0001);
        chk("seqC_count_after_rst", log_ca[c0 + 4], 3'd0);
        for (int k = 4; k < 19; k++) chk("seqC_grant_after_rst", log_ga[c0 + k], 4'h0);

        // GAP=0 instance: codes 2 and 3 give six contiguous grant cycles.
        c0 = cyc;
        drive(0, 1, 3'd2, 0);
        tick();
        drive(0, 1, 3'd3, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (12) tick();
        for (int k = 0; k < 6; k++) chk("seqD_grant_b", log_gb[c0 + 2 + k], (k < 3) ? 4'b0010 : 4'b0100);
        chk("seqD_grant_b_end", log_gb[c0 + 8], 4'h0);

        // Random traffic with occasional resets and error clears.
        for (int n = 0; n < 800; n++) begin
            int r;
            logic [2:0] p;
            r = $urandom_range(0, 9);
            if (r < 8) p = 3'(r % 4 + 1);
            else if (r == 8) p = 3'd0;
            else p = 3'($urandom_range(5, 7));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, p, $urandom_range(0, 15) == 0);
            tick();
        end
        drive(0, 0, 0, 0);
        repeat (30) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
